// File: rtl/button_lock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_lock_pkg
// Description : Shared types, constants and default parameter values for the
//               button combination lock controller.
// Revision    : 1.0 - initial release
// ============================================================================
package button_lock_pkg;

    // Lock controller states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    // Index of a pressed button (1..3); 0 marks an unusable entry
    typedef logic [1:0] btn_idx_t;

    localparam btn_idx_t INVALID_ENTRY = 2'b00;

    localparam int DEFAULT_DB_CYCLES   = 1250000;
    localparam int DEFAULT_SEQ_LEN     = 4;
    localparam int DEFAULT_MAX_TRIES   = 3;
    localparam int DEFAULT_LOCK_CYCLES = 625000000;

    // One-hot press vector to button index; simultaneous presses are invalid
    function automatic btn_idx_t btn_index(input logic [3:1] press);
        case (press)
            3'b001:  return 2'd1;
            3'b010:  return 2'd2;
            3'b100:  return 2'd3;
            default: return INVALID_ENTRY;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : One input channel: 2-flop synchronizer, stability counter and
//               rising-edge detector. Emits a one-cycle press pulse
//               DB_CYCLES+3 cycles after a clean raw rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DB_CYCLES = 1250000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_press
);

    localparam int c_cnt_w = $clog2(DB_CYCLES + 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic               r_prev;
    logic               r_press;
    logic [c_cnt_w-1:0] r_cnt;
    logic [1:0]         r_fill;
    // Suppresses presses from a button already held when reset released
    logic               r_block;

    // Synchronize, debounce, detect rising edge of the debounced level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_prev   <= 1'b0;
            r_press  <= 1'b0;
            r_cnt    <= '0;
            r_fill   <= 2'd0;
            r_block  <= 1'b1;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_stable) begin
                if (r_cnt == c_cnt_w'(DB_CYCLES - 1)) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end else begin
                r_cnt <= '0;
            end
            r_prev  <= r_stable;
            r_press <= r_stable & ~r_prev & ~r_block;
            if (r_fill != 2'd2) begin
                r_fill <= r_fill + 2'd1;
            end
            // Once the synchronizer reflects the real input, a low button arms
            if (r_block && (r_fill == 2'd2) && !r_sync2 && !r_stable) begin
                r_block <= 1'b0;
            end
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/button_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : button_lock_ctrl
// Description : Combination lock driven by three entry buttons and a check
//               button. Compares the entered sequence against code, flags
//               pass/fail and locks out after repeated failures.
// Revision    : 1.0 - initial release
// ============================================================================
module button_lock_ctrl
    import button_lock_pkg::*;
#(
    parameter int DB_CYCLES   = DEFAULT_DB_CYCLES,
    parameter int SEQ_LEN     = DEFAULT_SEQ_LEN,
    parameter int MAX_TRIES   = DEFAULT_MAX_TRIES,
    parameter int LOCK_CYCLES = DEFAULT_LOCK_CYCLES
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [3:1]           btn_raw,
    input  logic                 check,
    input  logic [2*SEQ_LEN-1:0] code,
    output logic                 blue,
    output logic                 red,
    output logic                 locked
);

    localparam int c_cnt_w = $clog2(SEQ_LEN + 1);
    localparam int c_try_w = $clog2(MAX_TRIES + 1);
    localparam int c_tmr_w = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    logic [3:1]           w_btn_press;
    logic                 w_check_press;
    logic                 w_btn_any;
    btn_idx_t             w_btn_idx;
    logic                 w_match;

    state_t               r_state,      w_state_nxt;
    logic [c_cnt_w-1:0]   r_count,      w_count_nxt;
    logic [2*SEQ_LEN-1:0] r_entries,    w_entries_nxt;
    logic [c_try_w-1:0]   r_tries,      w_tries_nxt;
    logic [c_tmr_w-1:0]   r_lock_timer, w_timer_nxt;
    logic                 r_blue, r_red, r_locked;

    for (genvar g = 1; g <= 3; g++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk     (clk),
            .rst     (clr),
            .i_raw   (btn_raw[g]),
            .o_press (w_btn_press[g])
        );
    end

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_check (
        .clk     (clk),
        .rst     (clr),
        .i_raw   (check),
        .o_press (w_check_press)
    );

    assign w_btn_any = |w_btn_press;
    assign w_btn_idx = btn_index(w_btn_press);
    assign w_match   = (r_count == c_cnt_w'(SEQ_LEN)) && (r_entries == code);

    // Next-state, entry capture, retry and lockout timer logic
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_entries_nxt = r_entries;
        w_tries_nxt   = r_tries;
        w_timer_nxt   = r_lock_timer;
        case (r_state)
            ST_IDLE, ST_ENTRY: begin
                // Check takes priority; a coincident button press is dropped
                if (w_check_press) begin
                    if (w_match) begin
                        w_state_nxt = ST_PASS;
                        w_tries_nxt = '0;
                    end else begin
                        w_state_nxt = ST_FAIL;
                        w_tries_nxt = r_tries + c_try_w'(1);
                    end
                end else if (w_btn_any) begin
                    if (r_state == ST_IDLE) begin
                        w_entries_nxt      = '0;
                        w_entries_nxt[1:0] = w_btn_idx;
                        w_count_nxt        = c_cnt_w'(1);
                        w_state_nxt        = ST_ENTRY;
                    end else if (r_count < c_cnt_w'(SEQ_LEN)) begin
                        w_entries_nxt[2*int'(r_count) +: 2] = w_btn_idx;
                        w_count_nxt = r_count + c_cnt_w'(1);
                    end
                end
            end
            ST_PASS: begin
                w_state_nxt = ST_PASS;
            end
            ST_FAIL: begin
                if (r_tries >= c_try_w'(MAX_TRIES)) begin
                    w_state_nxt = ST_LOCKOUT;
                    w_timer_nxt = '0;
                end else if (w_btn_any) begin
                    w_entries_nxt      = '0;
                    w_entries_nxt[1:0] = w_btn_idx;
                    w_count_nxt        = c_cnt_w'(1);
                    w_state_nxt        = ST_ENTRY;
                end
            end
            ST_LOCKOUT: begin
                if (r_lock_timer == c_tmr_w'(LOCK_CYCLES - 1)) begin
                    w_state_nxt   = ST_IDLE;
                    w_tries_nxt   = '0;
                    w_count_nxt   = '0;
                    w_entries_nxt = '0;
                    w_timer_nxt   = '0;
                end else begin
                    w_timer_nxt = r_lock_timer + c_tmr_w'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and registered outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_entries    <= '0;
            r_tries      <= '0;
            r_lock_timer <= '0;
            r_blue       <= 1'b0;
            r_red        <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_entries    <= w_entries_nxt;
            r_tries      <= w_tries_nxt;
            r_lock_timer <= w_timer_nxt;
            r_blue       <= (w_state_nxt == ST_PASS);
            r_red        <= (w_state_nxt == ST_FAIL) || (w_state_nxt == ST_LOCKOUT);
            r_locked     <= (w_state_nxt == ST_LOCKOUT);
        end
    end

    assign blue   = r_blue;
    assign red    = r_red;
    assign locked = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_button_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_lock_ctrl
// Description : Self-checking bench for button_lock_ctrl with directed
//               scenarios and randomized entry sequences against a
//               behavioural lock model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_lock_ctrl;
    import button_lock_pkg::*;

    localparam int DB   = 4;
    localparam int SEQ  = 4;
    localparam int MAXT = 3;
    localparam int LOCK = 50;
    localparam logic [7:0] CODE = {2'd1, 2'd1, 2'd3, 2'd2};

    localparam int M_OPEN = 0;
    localparam int M_PASS = 1;
    localparam int M_FAIL = 2;
    localparam int M_LOCK = 3;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:1] btn_raw;
    logic       check;
    logic [7:0] code;
    logic       blue, red, locked;
    logic [2:0] obs;

    int n_vec = 0;
    int n_err = 0;

    int code_q[4] = '{2, 3, 1, 1};
    int m_q[$];
    int m_tries;
    int m_mode;

    always #5 clk = ~clk;

    assign obs = {blue, red, locked};

    button_lock_ctrl #(
        .DB_CYCLES   (DB),
        .SEQ_LEN     (SEQ),
        .MAX_TRIES   (MAXT),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .btn_raw (btn_raw),
        .check   (check),
        .code    (code),
        .blue    (blue),
        .red     (red),
        .locked  (locked)
    );

    // ---------------- reference model ----------------
    function automatic int mask_to_idx(input logic [3:1] m);
        case (m)
            3'b001:  return 1;
            3'b010:  return 2;
            3'b100:  return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] m_out();
        return {m_mode == M_PASS, (m_mode == M_FAIL) || (m_mode == M_LOCK), m_mode == M_LOCK};
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_tries = 0;
        m_mode  = M_OPEN;
    endtask

    task automatic m_press(input logic [3:1] m);
        if (m_mode == M_LOCK || m_mode == M_PASS) return;
        if (m_mode == M_FAIL) begin
            m_q.delete();
            m_mode = M_OPEN;
        end
        if (m_q.size() < SEQ) m_q.push_back(mask_to_idx(m));
    endtask

    task automatic m_check();
        bit ok;
        if (m_mode != M_OPEN) return;
        ok = (m_q.size() == SEQ);
        if (ok) foreach (code_q[i]) if (m_q[i] != code_q[i]) ok = 0;
        if (ok) begin
            m_mode  = M_PASS;
            m_tries = 0;
        end else begin
            m_tries++;
            m_mode = (m_tries >= MAXT) ? M_LOCK : M_FAIL;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick(2);
        clr = 1'b0;
        tick(1);
        m_reset();
    endtask

    task automatic press(input logic [3:1] mask);
        btn_raw = mask;
        tick(DB + 2 + int'($urandom_range(0, 3)));
        btn_raw = 3'b000;
        tick(DB + 4 + int'($urandom_range(0, 3)));
        m_press(mask);
    endtask

    task automatic press_idx(input int idx);
        logic [3:1] m;
        m = 3'b001 << (idx - 1);
        press(m);
    endtask

    task automatic press_check();
        check = 1'b1;
        tick(DB + 4);
        check = 1'b0;
        tick(DB + 4);
        m_check();
    endtask

    task automatic enter_code();
        foreach (code_q[i]) press_idx(code_q[i]);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        btn_raw = 3'b000;
        check   = 1'b0;
        code    = CODE;
        clr     = 1'b1;
        tick(3);
        n_vec++;
        if (obs !== 3'b000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 000", obs);
        end
        n_vec++;
        if (dut.r_count !== 3'd0 || dut.r_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_state: got count %0d state %0d expected 0 IDLE", dut.r_count, dut.r_state);
        end
        clr = 1'b0;
        tick(1);
        m_reset();
    endtask

    task automatic test_pass();
        do_clr();
        enter_code();
        check = 1'b1;
        tick(DB + 3);
        n_vec++;
        if (obs !== 3'b000) begin
            n_err++;
            $display("FAIL pass_early: got %b expected 000", obs);
        end
        tick(1);
        n_vec++;
        if (obs !== 3'b100) begin
            n_err++;
            $display("FAIL pass_blue: got %b expected 100", obs);
        end
        n_vec++;
        if (dut.r_tries !== 2'd0) begin
            n_err++;
            $display("FAIL pass_tries: got %0d expected 0", dut.r_tries);
        end
        check = 1'b0;
        tick(DB + 4);
        m_check();
    endtask

    task automatic test_fail_recover();
        do_clr();
        press_idx(3); press_idx(3); press_idx(2); press_idx(1);
        press_check();
        n_vec++;
        if (obs !== 3'b010) begin
            n_err++;
            $display("FAIL fail_red: got %b expected 010", obs);
        end
        press_idx(2);
        n_vec++;
        if (obs !== 3'b000 || dut.r_state !== ST_ENTRY) begin
            n_err++;
            $display("FAIL fail_recover: got %b state %0d expected 000 ENTRY", obs, dut.r_state);
        end
    endtask

    task automatic test_lockout();
        do_clr();
        press_check();
        n_vec++;
        if (obs !== 3'b010) begin
            n_err++;
            $display("FAIL lock_fail1: got %b expected 010", obs);
        end
        press_idx(1);
        press_check();
        n_vec++;
        if (obs !== 3'b010) begin
            n_err++;
            $display("FAIL lock_fail2: got %b expected 010", obs);
        end
        press_idx(1);
        check = 1'b1;
        tick(DB + 4);
        n_vec++;
        if (obs !== 3'b010) begin
            n_err++;
            $display("FAIL lock_fail3: got %b expected 010", obs);
        end
        tick(1);
        n_vec++;
        if (obs !== 3'b011) begin
            n_err++;
            $display("FAIL lock_enter: got %b expected 011", obs);
        end
        check   = 1'b0;
        btn_raw = 3'b010;
        tick(DB + 2);
        btn_raw = 3'b000;
        tick(LOCK - 1 - (DB + 2));
        n_vec++;
        if (obs !== 3'b011) begin
            n_err++;
            $display("FAIL lock_hold: got %b expected 011", obs);
        end
        tick(1);
        n_vec++;
        if (obs !== 3'b000 || dut.r_state !== ST_IDLE || dut.r_tries !== 2'd0) begin
            n_err++;
            $display("FAIL lock_exit: got %b state %0d tries %0d expected 000 IDLE 0", obs, dut.r_state, dut.r_tries);
        end
        m_reset();
        tick(DB + 4);
        enter_code();
        press_check();
        n_vec++;
        if (obs !== 3'b100) begin
            n_err++;
            $display("FAIL lock_then_pass: got %b expected 100", obs);
        end
    endtask

    task automatic test_glitch();
        logic [3:1] m;
        do_clr();
        btn_raw = 3'b010;
        tick(2);
        btn_raw = 3'b000;
        tick(15);
        for (int i = 0; i < 4; i++) begin
            m = 3'b001 << $urandom_range(0, 2);
            btn_raw = m;
            tick(int'($urandom_range(1, DB - 1)));
            btn_raw = 3'b000;
            tick(DB + 6);
        end
        n_vec++;
        if (dut.r_count !== 3'd0 || dut.r_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL glitch: got count %0d state %0d expected 0 IDLE", dut.r_count, dut.r_state);
        end
    endtask

    task automatic test_multi();
        do_clr();
        press(3'b110);
        press_idx(3); press_idx(1); press_idx(1);
        press_check();
        n_vec++;
        if (obs !== 3'b010) begin
            n_err++;
            $display("FAIL multi_invalid: got %b expected 010", obs);
        end
        enter_code();
        press_idx(3);
        press_check();
        n_vec++;
        if (obs !== 3'b100) begin
            n_err++;
            $display("FAIL extra_ignored: got %b expected 100", obs);
        end
    endtask

    task automatic test_clr_mid();
        do_clr();
        press_idx(2); press_idx(3);
        clr = 1'b1;
        tick(1);
        n_vec++;
        if (obs !== 3'b000 || dut.r_count !== 3'd0) begin
            n_err++;
            $display("FAIL clr_mid: got %b count %0d expected 000 0", obs, dut.r_count);
        end
        clr = 1'b0;
        tick(1);
        m_reset();
        enter_code();
        press_check();
        n_vec++;
        if (obs !== 3'b100) begin
            n_err++;
            $display("FAIL clr_then_pass: got %b expected 100", obs);
        end
    endtask

    task automatic test_held_reset();
        btn_raw = 3'b001;
        clr = 1'b1;
        tick(2);
        clr = 1'b0;
        m_reset();
        tick(DB + 10);
        n_vec++;
        if (dut.r_count !== 3'd0) begin
            n_err++;
            $display("FAIL held_reset: got count %0d expected 0", dut.r_count);
        end
        btn_raw = 3'b000;
        tick(DB + 6);
        press_idx(1);
        n_vec++;
        if (dut.r_count !== 3'd1 || dut.r_state !== ST_ENTRY) begin
            n_err++;
            $display("FAIL held_repress: got count %0d state %0d expected 1 ENTRY", dut.r_count, dut.r_state);
        end
    endtask

    task automatic test_random();
        int         kind;
        int         len;
        int         tmp;
        logic [3:1] m;
        for (int r = 0; r < 10; r++) begin
            do_clr();
            for (int a = 0; a < 4; a++) begin
                kind = int'($urandom_range(0, 2));
                if (kind == 0) begin
                    enter_code();
                    if ($urandom_range(0, 1) == 1) press_idx(int'($urandom_range(1, 3)));
                end else if (kind == 1) begin
                    len = int'($urandom_range(0, 5));
                    for (int i = 0; i < len; i++) begin
                        if ($urandom_range(0, 7) == 0) press(3'b011);
                        else press_idx(int'($urandom_range(1, 3)));
                    end
                end else begin
                    tmp = int'($urandom_range(0, SEQ - 1));
                    for (int i = 0; i < SEQ; i++) begin
                        if (i == tmp) begin
                            m = 3'b001 << $urandom_range(0, 2);
                            press(m);
                        end else begin
                            press_idx(code_q[i]);
                        end
                    end
                end
                press_check();
                n_vec++;
                if (obs !== m_out()) begin
                    n_err++;
                    $display("FAIL rand_out r%0d a%0d: got %b expected %b", r, a, obs, m_out());
                end
                if (m_mode == M_LOCK) begin
                    tick(LOCK + 5);
                    m_reset();
                    n_vec++;
                    if (obs !== m_out()) begin
                        n_err++;
                        $display("FAIL rand_unlock r%0d: got %b expected %b", r, obs, m_out());
                    end
                    break;
                end
                if (m_mode == M_PASS) break;
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail_recover();
        test_lockout();
        test_glitch();
        test_multi();
        test_clr_mid();
        test_held_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
